// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential MIPS multiply/divide unit: op codes,
// FSM state constants and the iteration count.
package muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_ABS_A  = 3'd1;
  localparam state_t S_ABS_B  = 3'd2;
  localparam state_t S_CALC   = 3'd3;
  localparam state_t S_SGN_LO = 3'd4;
  localparam state_t S_SGN_HI = 3'd5;
  localparam state_t S_DONE   = 3'd6;

  localparam int ITERS = 32;

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups with the
// group carries chained between them.
module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [31:0] p;
  logic [31:0] g;
  logic [31:0] c;
  logic [8:0]  gc;

  always_comb begin
    p  = a ^ b;
    g  = a & b;
    c  = '0;
    gc = '0;
    gc[0] = ci;
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      gc[k+1]  = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    s  = p ^ c;
    co = gc[8];
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit sharing one cla32 for every step.
// Optional MULDIV_CANCEL_EN adds a cancel input that aborts and restores hi/lo/dz.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef MULDIV_CANCEL_EN
  input  logic             cancel,
`endif
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] opnd;
  logic             sign_a;
  logic             sign_b;
  logic             c_lo;

  logic             is_div;
  logic             neg_q;
  logic             accept;
  logic             b_zero;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] abs_a_x;
  logic [WIDTH-1:0] abs_b_x;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_ci;
  logic [WIDTH-1:0] sum;
  logic             co;

`ifdef MULDIV_CANCEL_EN
  logic [WIDTH-1:0] hi_sv;
  logic [WIDTH-1:0] lo_sv;
  logic             dz_sv;
  logic             abort;
  assign abort = cancel && (state != S_IDLE);
`endif

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign is_div  = op_r[1];
  assign neg_q   = sign_a ^ sign_b;
  assign accept  = (state == S_IDLE) && start;
  assign b_zero  = (b == '0);
  assign rem_sh  = {hi[WIDTH-2:0], lo[WIDTH-1]};
  // Multiply keeps the multiplicand (a) in opnd and multiplier (b) in lo;
  // divide keeps the dividend (a) in lo and divisor (b) in opnd.
  assign abs_a_x = is_div ? lo : opnd;
  assign abs_b_x = is_div ? opnd : lo;

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    case (state)
      S_ABS_A: begin
        add_a  = ~abs_a_x;
        add_ci = 1'b1;
      end
      S_ABS_B: begin
        add_a  = ~abs_b_x;
        add_ci = 1'b1;
      end
      S_CALC: begin
        if (is_div) begin
          add_a  = rem_sh;
          add_b  = ~opnd;
          add_ci = 1'b1;
        end else begin
          add_a = hi;
          add_b = lo[0] ? opnd : '0;
        end
      end
      S_SGN_LO: begin
        add_a  = ~lo;
        add_ci = 1'b1;
      end
      S_SGN_HI: begin
        add_a  = ~hi;
        add_ci = is_div ? 1'b1 : c_lo;
      end
      default: ;
    endcase
  end

  cla32 u_cla32 (
    .a  (add_a),
    .b  (add_b),
    .ci (add_ci),
    .s  (sum),
    .co (co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      dz    <= 1'b0;
`ifdef MULDIV_CANCEL_EN
    end else if (abort) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= hi_sv;
      lo    <= lo_sv;
      dz    <= dz_sv;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt <= '0;
            dz  <= op[1] && b_zero;
            if (op[1] && b_zero) begin
              hi    <= a;
              lo    <= '1;
              state <= S_DONE;
            end else begin
              hi    <= '0;
              lo    <= op[1] ? a : b;
              state <= op[0] ? S_ABS_A : S_CALC;
            end
          end
        end
        S_ABS_A: begin
          if (sign_a && is_div) lo <= sum;
          state <= S_ABS_B;
        end
        S_ABS_B: begin
          if (sign_b && !is_div) lo <= sum;
          state <= S_CALC;
        end
        S_CALC: begin
          if (is_div) begin
            // A set shifted-out bit means rem_sh >= 2^32 > divisor, so the trial always commits.
            if (hi[WIDTH-1] || co) begin
              hi <= sum;
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= rem_sh;
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            {hi, lo} <= {co, sum, lo[WIDTH-1:1]};
          end
          if (cnt == CNT_W'(ITERS - 1)) begin
            cnt   <= '0;
            state <= op_r[0] ? S_SGN_LO : S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SGN_LO: begin
          if (neg_q) lo <= sum;
          state <= S_SGN_HI;
        end
        S_SGN_HI: begin
          if (is_div ? sign_a : neg_q) hi <= sum;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_r   <= op;
      opnd   <= op[1] ? b : a;
      sign_a <= op[0] & a[WIDTH-1];
      sign_b <= op[0] & b[WIDTH-1];
`ifdef MULDIV_CANCEL_EN
      hi_sv  <= hi;
      lo_sv  <= lo;
      dz_sv  <= dz;
`endif
    end else if (state == S_ABS_A && sign_a && !is_div) begin
      opnd <= sum;
    end else if (state == S_ABS_B && sign_b && is_div) begin
      opnd <= sum;
    end
    // Carry out of ~lo+1 feeds the high-word negation in the next state.
    if (state == S_SGN_LO) c_lo <= co;
  end

endmodule
